// File: rtl/fp_add_normalize.sv
// FP32 adder back end: signed add of pre-aligned mantissas, iterative one-bit-per-clock
// normalization, and truncating IEEE-754 single pack behind a valid/ready handshake.
module fp_add_normalize #(
  parameter int unsigned MAN_W = 24,
  parameter int unsigned EXP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W-1:0]       al_man_a,
  input  logic [MAN_W-1:0]       al_man_b,
  input  logic                   sign_a,
  input  logic                   sign_b,
  input  logic [EXP_W-1:0]       exp_max,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [MAN_W-1:0]       man_a_q, man_a_d, man_b_q, man_b_d;
  logic                   sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic                   sign_q, sign_d;
  logic [MAN_W:0]         acc_q, acc_d;
  logic [EXP_W-1:0]       exp_q, exp_d;
  logic [EXP_W+MAN_W-1:0] result_q, result_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;

  logic [MAN_W:0]         acc_shr;
  logic [EXP_W-1:0]       exp_inc;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  assign acc_shr = acc_q >> 1;
  assign exp_inc = exp_q + EXP_W'(1);

  always_comb begin
    state_d  = state_q;
    man_a_d  = man_a_q;
    man_b_d  = man_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    exp_d    = exp_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          man_a_d  = al_man_a;
          man_b_d  = al_man_b;
          sign_a_d = sign_a;
          sign_b_d = sign_b;
          exp_d    = exp_max;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          state_d  = ADD;
        end
      end
      ADD: begin
        if (sign_a_q == sign_b_q) begin
          acc_d  = {1'b0, man_a_q} + {1'b0, man_b_q};
          sign_d = sign_a_q;
        end else if (man_a_q >= man_b_q) begin
          acc_d  = {1'b0, man_a_q} - {1'b0, man_b_q};
          sign_d = sign_a_q;
        end else begin
          acc_d  = {1'b0, man_b_q} - {1'b0, man_a_q};
          sign_d = sign_b_q;
        end
        // A zero exponent denotes a denormal operand whose scale equals exponent 1.
        if (exp_q == '0) exp_d = EXP_W'(1);
        if (exp_q == '1) begin
          result_d = {sign_d, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = NORM;
        end
      end
      NORM: begin
        if (acc_q == '0) begin
          result_d = '0;
          state_d  = DONE;
        end else if (acc_q[MAN_W]) begin
          acc_d   = acc_shr;
          exp_d   = exp_inc;
          state_d = DONE;
          if (exp_inc == '1) begin
            result_d = {sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_inc, acc_shr[MAN_W-2:0]};
          end
        end else if (acc_q[MAN_W-1]) begin
          result_d = {sign_q, exp_q, acc_q[MAN_W-2:0]};
          state_d  = DONE;
        end else if (exp_q == EXP_W'(1)) begin
          result_d = {sign_q, {EXP_W{1'b0}}, acc_q[MAN_W-2:0]};
          unf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          acc_d = acc_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      man_a_q  <= '0;
      man_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      man_a_q  <= man_a_d;
      man_b_q  <= man_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Scoreboard bench for fp_add_normalize: directed operand sets with hand-computed
// FP32 results, flags and latency (clocks counted from the accepting edge, inclusive).
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] al_man_a = '0;
  logic [23:0] al_man_b = '0;
  logic        sign_a = 1'b0;
  logic        sign_b = 1'b0;
  logic [7:0]  exp_max = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        busy;

  fp_add_normalize #(.MAN_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .al_man_a(al_man_a), .al_man_b(al_man_b), .sign_a(sign_a), .sign_b(sign_b),
    .exp_max(exp_max), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard when a result first appears, then checks it is held.
  logic        prev_valid = 1'b0;
  logic [31:0] held_res;
  logic        held_ovf, held_unf;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
          chk({e.name, "_underflow"}, {31'd0, underflow}, {31'd0, e.unf});
          chk({e.name, "_latency"}, cyc - e.acc_cyc + 1, e.lat);
        end
        held_res = result;
        held_ovf = overflow;
        held_unf = underflow;
      end else if (out_valid && prev_valid) begin
        chk("held_result", result, held_res);
        chk("held_flags", {30'd0, overflow, underflow}, {30'd0, held_ovf, held_unf});
      end
      prev_valid <= out_valid;
    end
  end

  task automatic op(input string name, input logic [23:0] a, input logic [23:0] b,
                    input logic sa, input logic sb_, input logic [7:0] e,
                    input logic [31:0] res, input logic ovf, input logic unf, input int lat);
    exp_t x;
    int   t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk({name, "_in_ready_timeout"}, 32'd0, 32'd1);
    al_man_a = a; al_man_b = b; sign_a = sa; sign_b = sb_; exp_max = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x.name = name; x.res = res; x.ovf = ovf; x.unf = unf; x.lat = lat; x.acc_cyc = cyc;
    sb.push_back(x);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk({name, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("reset_result", result, 32'h0);
    chk("reset_flags", {29'd0, out_valid, overflow, underflow}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    op("add_1p1",     24'h800000, 24'h800000, 0, 0, 8'd127, 32'h40000000, 0, 0, 3);  drain("a");
    op("cancel",      24'hC00000, 24'hA00000, 0, 1, 8'd127, 32'h3E800000, 0, 0, 5);  drain("b");
    op("exact_zero",  24'h800000, 24'h800000, 0, 1, 8'd127, 32'h00000000, 0, 0, 3);  drain("c");
    op("overflow",    24'hFFFFFF, 24'hFFFFFF, 0, 0, 8'd254, 32'h7F800000, 1, 0, 3);  drain("d");
    op("underflow",   24'h800000, 24'h7FFFFF, 0, 1, 8'd1,   32'h00000001, 0, 1, 3);  drain("e");
    op("neg_add",     24'h800000, 24'h800000, 1, 1, 8'd127, 32'hC0000000, 0, 0, 3);  drain("f");
    op("b_larger",    24'hA00000, 24'hC00000, 0, 1, 8'd127, 32'hBE800000, 0, 0, 5);  drain("g");
    op("exp_inf",     24'h800000, 24'h800000, 1, 1, 8'd255, 32'hFF800000, 1, 0, 2);  drain("h");
    op("exp_zero",    24'h000001, 24'h000001, 0, 0, 8'd0,   32'h00000002, 0, 1, 3);  drain("i");
    op("max_shift",   24'h800000, 24'h7FFFFF, 0, 1, 8'd127, 32'h34000000, 0, 0, 26); drain("j");

    // Backpressure: hold the result and ignore new operands while out_ready is low.
    out_ready = 1'b0;
    op("bp", 24'h800000, 24'h800000, 0, 0, 8'd127, 32'h40000000, 0, 0, 3);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) chk("bp_out_valid_timeout", 32'd0, 32'd1);
    end
    al_man_a = 24'hFFFFFF; al_man_b = 24'h000001; exp_max = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during NORM discards the in-flight operation.
    op("aborted", 24'hC00000, 24'hA00000, 0, 1, 8'd127, 32'h3E800000, 0, 0, 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_flags", {29'd0, out_valid, overflow, underflow}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    op("after_reset", 24'hC00000, 24'hA00000, 0, 1, 8'd127, 32'h3E800000, 0, 0, 5);
    drain("k");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
- Stage directly downstream of the exponent compare/mantissa align stage in the FP32 adder path of the matrix multiplier's accumulate unit.
- Takes the two aligned 24-bit mantissas (hidden bit included), the operand signs and the larger exponent.
- Performs the signed mantissa add/subtract, then normalizes iteratively with one left shift per clock.
- Packs an IEEE-754 single result (truncation rounding) behind a valid/ready handshake.

Parameters:
- MAN_W, 24, aligned mantissa width including hidden bit.
- EXP_W, 8, exponent width.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- al_man_a  input  24  aligned mantissa A.
- al_man_b  input  24  aligned mantissa B.
- sign_a  input  1  sign of A.
- sign_b  input  1  sign of B.
- exp_max  input  8  larger of the two biased exponents.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  packed FP32 sum.
- overflow  output  1  result saturated to infinity.
- underflow  output  1  result is denormal or exact zero via exponent limit.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately.
  - All state and outputs clear: state=IDLE, result=0, overflow=0, underflow=0, out_valid=0.
  - Any in-flight operation is discarded.
  - in_ready=1 once rst_n is high.
- FSM states: IDLE, ADD, NORM, DONE.
  - in_ready = (state==IDLE), combinational. out_valid = (state==DONE). busy = !IDLE.
- IDLE:
  - On in_valid & in_ready, register all operands and go to ADD.
  - In all other states, in_valid is ignored.
- ADD (1 cycle): compute the 25-bit accumulator acc.
  - Same signs: acc = a + b, sign = sign_a.
  - Different signs: if a >= b, acc = a - b and sign = sign_a; else acc = b - a and sign = sign_b.
  - Working exponent e = max(exp_max, 1); exp_max=0 is treated as a denormal input scale.
  - If exp_max==255: force result = {sign, 8'hFF, 23'b0}, overflow=1, go to DONE.
  - Otherwise go to NORM.
- NORM (evaluated each cycle, in priority order):
  1. acc==0: result = 0x00000000 (sign forced to 0), flags 0, go to DONE.
  2. acc[24]==1: acc >>= 1 (LSB truncated), e += 1.
     - If new e==255: result = {sign, 8'hFF, 0}, overflow=1.
     - Else result = {sign, e, acc[22:0]}.
     - Go to DONE.
  3. acc[23]==1: result = {sign, e, acc[22:0]}, go to DONE.
  4. e==1: result = {sign, 8'h00, acc[22:0]}, underflow=1, go to DONE.
  5. Otherwise: acc <<= 1, e -= 1, remain in NORM.
- DONE:
  - result and flags are held stable while out_valid=1.
  - On out_ready, go to IDLE next edge. The new in_valid can be accepted in the cycle after.
- Latency: out_valid rises 3 clocks after the acceptance edge, plus 1 clock per left shift. Maximum 3 + 23 = 26.
- Throughput: one operation in flight; no bypass between out_ready and in_ready.
- Flags are mutually exclusive and are cleared on each acceptance.

Test Plan:
- Same-sign add, no shift: a=b=0x800000, exp_max=127, signs 0 (1.0 + 1.0).
  - Expect result=0x40000000, flags 0, out_valid 3 clocks after accept.
- Cancellation with shifts: a=0xC00000, b=0xA00000, exp_max=127, sign_b=1 (1.5 - 1.25).
  - Expect result=0x3E800000 (0.25), out_valid 5 clocks after accept.
- Exact cancellation: a=b=0x800000, sign_a=0, sign_b=1.
  - Expect result=0x00000000, flags 0.
- Overflow: a=b=0xFFFFFF, exp_max=254, signs 0.
  - Expect result=0x7F800000, overflow=1.
- Underflow: a=0x800000, b=0x7FFFFF, sign_b=1, exp_max=1.
  - Expect result=0x00000001, underflow=1, out_valid 3 clocks after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: result stays constant, in_ready=0, a new in_valid is ignored.
  - Then accept a 0xC00000/0xA00000 cancel operation and drop rst_n during NORM.
  - Expect all outputs 0 immediately, in_ready=1 after release, and the next operation completes correctly.
